spi_cfg_master: RTL and testbench

Parametrised SPI master for configuring ADCs and other peripherals over a shared bus. It serialises one DATA_W-bit word per transaction in any of the four CPOL/CPHA modes, on one of NUM_CS chip selects, with a programmable SCLK divider. It uses a start/busy/done handshake and optionally captures MISO readback. It sits between the board-level control logic and the converter pins, and replaces fixed-width, fixed-address SPI config blocks.

---
 rtl/spi_cfg_master.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_cfg_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: parametrised SPI configuration master.
// One DATA_W-bit word is sent MSB first per transaction.
// Any of the four CPOL/CPHA modes can be used, on one of NUM_CS chip selects.
// The start/busy/done handshake wraps each frame.
// Optional feature macro: SPI_CFG_READBACK_EN.
//   Defined: MISO is captured and presented on rx_data at done.
//   Undefined: rx_data is tied to zero and miso is ignored.
module spi_cfg_master #(
  parameter int DATA_W  = 32,
  parameter int NUM_CS  = 2,
  parameter int SEL_W   = 1,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [SEL_W-1:0]  cs_sel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [EW-1:0] EDGE_ONE  = EW'(1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [DW-1:0]       div_r, div_s;
  logic [EW-1:0]       edge_r, edge_s;
  logic [DATA_W-1:0]   sh_r, sh_s;
  logic                cpol_q_r, cpol_q_s;
  logic                cpha_q_r, cpha_q_s;
  logic [SEL_W-1:0]    sel_r, sel_s;
  logic                cpol_idle_r;
  logic                sclk_r, sclk_s;
  logic                mosi_r, mosi_s;
  logic [NUM_CS-1:0]   cs_n_r, cs_n_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                valid_sel_s;
  logic                leading_s;
`ifdef SPI_CFG_READBACK_EN
  logic [DATA_W-1:0]   rx_sh_r, rx_sh_s;
  logic [DATA_W-1:0]   rx_data_r, rx_data_s;
`else
  logic                unused_miso_s;
`endif

  assign valid_sel_s = ({1'b0, cs_sel} < (SEL_W + 1)'(NUM_CS));
  // Edges are numbered from 1, so an even count of edges done means the next edge is odd (leading).
  assign leading_s   = ~edge_r[0];

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s  = state_r;
    div_s    = div_r;
    edge_s   = edge_r;
    sh_s     = sh_r;
    cpol_q_s = cpol_q_r;
    cpha_q_s = cpha_q_r;
    sel_s    = sel_r;
    sclk_s   = sclk_r;
    mosi_s   = mosi_r;
    cs_n_s   = cs_n_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
`ifdef SPI_CFG_READBACK_EN
    rx_sh_s   = rx_sh_r;
    rx_data_s = rx_data_r;
`endif
    case (state_r)
      IDLE: begin
        sclk_s = cpol_idle_r;
        mosi_s = 1'b0;
        cs_n_s = '1;
        busy_s = 1'b0;
        if (start && valid_sel_s) begin
          state_s  = SETUP;
          div_s    = DIV_MAX;
          edge_s   = '0;
          sh_s     = tx_data;
          cpol_q_s = cpol;
          cpha_q_s = cpha;
          sel_s    = cs_sel;
          sclk_s   = cpol;
          // In CPHA=0 the slave samples on the very first edge, so the MSB must be on the wire already.
          mosi_s   = cpha ? 1'b0 : tx_data[DATA_W-1];
          cs_n_s   = ~(NUM_CS'(1) << cs_sel);
          busy_s   = 1'b1;
`ifdef SPI_CFG_READBACK_EN
          rx_sh_s  = '0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (div_r == '0) begin
          state_s = SHIFT;
          div_s   = DIV_MAX;
        end else begin
          div_s = div_r - DIV_ONE;
        end
      end
      SHIFT: begin
        if (div_r == '0) begin
          div_s  = DIV_MAX;
          sclk_s = ~sclk_r;
          edge_s = edge_r + EDGE_ONE;
`ifdef SPI_CFG_READBACK_EN
          // Capture uses the miso value present before this SCLK edge.
          if (leading_s ^ cpha_q_r) begin
            rx_sh_s = {rx_sh_r[DATA_W-2:0], miso};
          end else begin
            rx_sh_s = rx_sh_r;
          end
`endif
          if (cpha_q_r) begin
            if (leading_s) begin
              mosi_s = sh_r[DATA_W-1];
              sh_s   = sh_r << 1;
            end else begin
              mosi_s = mosi_r;
            end
          end else begin
            // Last trailing edge does not shift, so mosi keeps the LSB into HOLD.
            if (!leading_s && (edge_r != LAST_EDGE)) begin
              mosi_s = sh_r[DATA_W-2];
              sh_s   = sh_r << 1;
            end else begin
              mosi_s = mosi_r;
            end
          end
          if (edge_r == LAST_EDGE) begin
            state_s = HOLD;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          div_s = div_r - DIV_ONE;
        end
      end
      HOLD: begin
        if (div_r == '0) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          cs_n_s  = '1;
          mosi_s  = 1'b0;
`ifdef SPI_CFG_READBACK_EN
          rx_data_s = rx_sh_r;
`endif
        end else begin
          div_s = div_r - DIV_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        cs_n_s  = '1;
        mosi_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update; reset returns every output to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      div_r       <= '0;
      edge_r      <= '0;
      sh_r        <= '0;
      cpol_q_r    <= 1'b0;
      cpha_q_r    <= 1'b0;
      sel_r       <= '0;
      cpol_idle_r <= 1'b0;
      sclk_r      <= 1'b0;
      mosi_r      <= 1'b0;
      cs_n_r      <= '1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      edge_r      <= edge_s;
      sh_r        <= sh_s;
      cpol_q_r    <= cpol_q_s;
      cpha_q_r    <= cpha_q_s;
      sel_r       <= sel_s;
      cpol_idle_r <= cpol;
      sclk_r      <= sclk_s;
      mosi_r      <= mosi_s;
      cs_n_r      <= cs_n_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

`ifdef SPI_CFG_READBACK_EN
  // MISO capture shift register and the readback word presented at done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh_r   <= '0;
      rx_data_r <= '0;
    end else begin
      rx_sh_r   <= rx_sh_s;
      rx_data_r <= rx_data_s;
    end
  end
  assign rx_data = rx_data_r;
`else
  assign unused_miso_s = miso;
  assign rx_data       = '0;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign sclk = sclk_r;
  assign mosi = mosi_r;
  assign cs_n = cs_n_r;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed testbench for spi_cfg_master.
// Covers reset, the SPI modes, readback, back-to-back frames, mid-frame reset and an invalid chip select.
module tb_spi_cfg_master;

  localparam int DATA_W  = 32;
  localparam int NUM_CS  = 2;
  localparam int SEL_W   = 2;
  localparam int CLK_DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic [SEL_W-1:0]  cs_sel = '0;
  logic              busy, done, sclk, mosi;
  logic              miso;
  logic [DATA_W-1:0] rx_data;
  logic [NUM_CS-1:0] cs_n;

  int n_vec = 0;
  int n_err = 0;

  spi_cfg_master #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .SEL_W(SEL_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .cs_sel(cs_sel), .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: presents the next bit after every falling SCLK edge while selected.
  logic [DATA_W-1:0] slave_pat = 32'hA5A5_A5A5;
  int                slave_idx = 0;
  wire               cs_idle = &cs_n;
  always @(negedge sclk or posedge cs_idle) begin
    if (cs_idle) slave_idx = 0;
    else         slave_idx = slave_idx + 1;
  end
  assign miso = (slave_idx < DATA_W) ? slave_pat[DATA_W-1-slave_idx] : 1'b0;

`ifdef SPI_CFG_READBACK_EN
  localparam logic [DATA_W-1:0] EXP_RX = 32'hA5A5_A5A5;
`else
  localparam logic [DATA_W-1:0] EXP_RX = 32'h0000_0000;
`endif

  // Runs one frame and gathers observations; the calling test does the comparisons.
  task automatic run_frame(input logic [DATA_W-1:0] tx, input logic pol, input logic pha,
                           input logic [SEL_W-1:0] sel,
                           output int busy_cyc, output int cs_err, output logic [DATA_W-1:0] word,
                           output int nbits, output int done_cnt, output logic first_mosi,
                           output logic [DATA_W-1:0] rx_at_done, output logic tmo);
    logic              prev;
    logic              smp_lvl;
    logic              seen;
    logic [NUM_CS-1:0] exp_cs;
    busy_cyc = 0; cs_err = 0; word = '0; nbits = 0; done_cnt = 0;
    first_mosi = 1'b0; rx_at_done = '0; seen = 1'b0;
    exp_cs = '1;
    exp_cs[sel] = 1'b0;
    smp_lvl = (pol == pha);
    @(negedge clk);
    cpol = pol; cpha = pha; cs_sel = sel; tx_data = tx;
    repeat (3) @(negedge clk);
    prev = sclk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_data = ~tx;
    cs_sel = sel ^ 2'd1;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (busy) begin
        if (busy_cyc == 0) first_mosi = mosi;
        busy_cyc++;
        if (cs_n !== exp_cs) cs_err++;
      end
      if (sclk !== prev && sclk === smp_lvl) begin
        word = {word[DATA_W-2:0], mosi};
        nbits++;
      end
      prev = sclk;
      if (done) begin
        done_cnt++;
        rx_at_done = rx_data;
        seen = 1'b1;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    cs_sel = sel;
    tmo = !seen;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (cs_n !== 2'b11) begin n_err++; $display("FAIL reset_cs_n got=%b exp=11", cs_n); end
    n_vec++; if (sclk !== 1'b0 || mosi !== 1'b0) begin n_err++; $display("FAIL reset_sclk_mosi got=%b%b exp=00", sclk, mosi); end
    n_vec++; if (rx_data !== 32'h0) begin n_err++; $display("FAIL reset_rx got=%h exp=0", rx_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_sclk();
    cpol = 1'b1;
    @(negedge clk);
    n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL idle_sclk_delay got=%b exp=0", sclk); end
    @(negedge clk);
    n_vec++; if (sclk !== 1'b1) begin n_err++; $display("FAIL idle_sclk_follow got=%b exp=1", sclk); end
    n_vec++; if (mosi !== 1'b0) begin n_err++; $display("FAIL idle_mosi got=%b exp=0", mosi); end
  endtask

  task automatic test_mode3();
    int bc, ce, nb, dc; logic [DATA_W-1:0] w, rx; logic fm, tmo;
    run_frame(32'hF800_0001, 1'b1, 1'b1, 2'd0, bc, ce, w, nb, dc, fm, rx, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL m3_timeout got=%b exp=0", tmo); end
    n_vec++; if (bc != 264) begin n_err++; $display("FAIL m3_busy_cycles got=%0d exp=264", bc); end
    n_vec++; if (ce != 0) begin n_err++; $display("FAIL m3_cs_n got=%0d bad cycles exp=0", ce); end
    n_vec++; if (nb != 32 || w !== 32'hF800_0001) begin n_err++; $display("FAIL m3_mosi got=%h/%0d exp=f8000001/32", w, nb); end
    n_vec++; if (dc != 1) begin n_err++; $display("FAIL m3_done_pulses got=%0d exp=1", dc); end
    n_vec++; if (sclk !== 1'b1) begin n_err++; $display("FAIL m3_sclk_idle got=%b exp=1", sclk); end
  endtask

  task automatic test_mode2();
    int bc, ce, nb, dc; logic [DATA_W-1:0] w, rx; logic fm, tmo;
    run_frame(32'hF400_00FF, 1'b1, 1'b0, 2'd1, bc, ce, w, nb, dc, fm, rx, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL m2_timeout got=%b exp=0", tmo); end
    n_vec++; if (fm !== 1'b1) begin n_err++; $display("FAIL m2_msb_setup got=%b exp=1", fm); end
    n_vec++; if (ce != 0) begin n_err++; $display("FAIL m2_cs_n got=%0d bad cycles exp=0", ce); end
    n_vec++; if (nb != 32 || w !== 32'hF400_00FF) begin n_err++; $display("FAIL m2_mosi got=%h/%0d exp=f40000ff/32", w, nb); end
    n_vec++; if (bc != 264) begin n_err++; $display("FAIL m2_busy_cycles got=%0d exp=264", bc); end
  endtask

  task automatic test_readback();
    int bc, ce, nb, dc; logic [DATA_W-1:0] w, rx; logic fm, tmo;
    run_frame(32'h1234_5678, 1'b0, 1'b0, 2'd0, bc, ce, w, nb, dc, fm, rx, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL rb_timeout got=%b exp=0", tmo); end
    n_vec++; if (rx !== EXP_RX) begin n_err++; $display("FAIL rb_rx_at_done got=%h exp=%h", rx, EXP_RX); end
    n_vec++; if (rx_data !== EXP_RX) begin n_err++; $display("FAIL rb_rx_hold got=%h exp=%h", rx_data, EXP_RX); end
    n_vec++; if (nb != 32 || w !== 32'h1234_5678) begin n_err++; $display("FAIL rb_mosi got=%h/%0d exp=12345678/32", w, nb); end
  endtask

  task automatic test_back_to_back();
    int c, d1, d2, gap, ndone;
    logic gap_open, seen_d1;
    d1 = -1; d2 = -1; gap = 0; ndone = 0; gap_open = 1'b0; seen_d1 = 1'b0;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0; tx_data = 32'h0F0F_0F0F;
    repeat (3) @(negedge clk);
    start = 1'b1;
    for (c = 0; c < 700 && d2 < 0; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (!seen_d1) begin d1 = c; seen_d1 = 1'b1; gap_open = 1'b1; end
        else d2 = c;
      end
      if (gap_open) begin
        if (cs_idle) gap++;
        else gap_open = 1'b0;
      end
      if (seen_d1 && busy) start = 1'b0;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (ndone != 2) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
    n_vec++; if (d2 - d1 != 265) begin n_err++; $display("FAIL b2b_done_spacing got=%0d exp=265", d2 - d1); end
    n_vec++; if (gap != 1) begin n_err++; $display("FAIL b2b_cs_gap got=%0d exp=1", gap); end
  endtask

  task automatic test_reset_mid_frame();
    int bc, ce, nb, dc, nd; logic [DATA_W-1:0] w, rx; logic fm, tmo;
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b1; cs_sel = 2'd0; tx_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (cs_n !== 2'b11) begin n_err++; $display("FAIL rstmid_cs_n got=%b exp=11", cs_n); end
    n_vec++; if (sclk !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_sclk_busy got=%b%b exp=00", sclk, busy); end
    n_vec++; if (rx_data !== 32'h0 || mosi !== 1'b0) begin n_err++; $display("FAIL rstmid_rx_mosi got=%h/%b exp=0/0", rx_data, mosi); end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    n_vec++; if (nd != 0) begin n_err++; $display("FAIL rstmid_no_done got=%0d exp=0", nd); end
    run_frame(32'h3C00_00C3, 1'b0, 1'b1, 2'd1, bc, ce, w, nb, dc, fm, rx, tmo);
    n_vec++; if (tmo !== 1'b0 || dc != 1) begin n_err++; $display("FAIL rstmid_next_done got=%0d/%b exp=1/0", dc, tmo); end
    n_vec++; if (nb != 32 || w !== 32'h3C00_00C3 || bc != 264 || ce != 0) begin
      n_err++; $display("FAIL rstmid_next_frame got=%h/%0d/%0d/%0d exp=3c0000c3/32/264/0", w, nb, bc, ce);
    end
  endtask

  task automatic test_bad_sel();
    int bb, bc, bd, bs; logic s0;
    bb = 0; bc = 0; bd = 0; bs = 0;
    @(negedge clk);
    s0 = sclk;
    cs_sel = 2'd2; tx_data = 32'hFFFF_FFFF; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy !== 1'b0) bb++;
      if (cs_n !== 2'b11) bc++;
      if (done !== 1'b0) bd++;
      if (sclk !== s0) bs++;
    end
    cs_sel = 2'd0;
    n_vec++; if (bb != 0) begin n_err++; $display("FAIL badsel_busy got=%0d exp=0", bb); end
    n_vec++; if (bc != 0) begin n_err++; $display("FAIL badsel_cs_n got=%0d exp=0", bc); end
    n_vec++; if (bd != 0) begin n_err++; $display("FAIL badsel_done got=%0d exp=0", bd); end
    n_vec++; if (bs != 0) begin n_err++; $display("FAIL badsel_sclk got=%0d exp=0", bs); end
  endtask

  initial begin
    test_reset();
    test_idle_sclk();
    test_mode3();
    test_mode2();
    test_readback();
    test_back_to_back();
    test_reset_mid_frame();
    test_bad_sel();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
